// File: rtl/seq_table_engine.sv
// Table-driven sequencer: plays DEPTH frames of {masked trigger, two timed output phases}.
// Optional SEQ_PAUSE_EN adds pause_i, which freezes a running sequence in place.
module seq_table_engine #(
  parameter int NUM_INP = 4,
  parameter int NUM_OUT = 6,
  parameter int DEPTH   = 512
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
`ifdef SEQ_PAUSE_EN
  input  logic               pause_i,
`endif
  input  logic [NUM_INP-1:0] inp_i,
  output logic [NUM_OUT-1:0] out_o,
  output logic               active_o,
  input  logic [31:0]        PRESCALE,
  input  logic               TABLE_START,
  input  logic [31:0]        TABLE_DATA,
  input  logic               TABLE_WSTB,
  input  logic [15:0]        TABLE_LENGTH,
  input  logic               TABLE_LENGTH_WSTB,
  input  logic [31:0]        TABLE_CYCLE,
  output logic [31:0]        CUR_FRAME,
  output logic [31:0]        CUR_FCYCLE,
  output logic [31:0]        CUR_TCYCLE,
  output logic [1:0]         HEALTH
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORDS = 4 * DEPTH;
  localparam int WPW   = AW + 3;

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, PHASE1, PHASE2} state_t;

  state_t          state, state_n;
  logic [31:0]     mem [WORDS];
  logic [WPW-1:0]  wptr;
  logic [15:0]     tbl_len;
  logic            en_q;
  logic [31:0]     pre_cnt, tick_cnt, ps_lat;
  logic [31:0]     w0, w1, w2, w3, ph_ticks, ph_tgt;
  logic            hold, en_rise, en_fall, trig_hit, in_phase, pre_wrap, phase_end;
  logic            rep_more, last_frame, cyc_done, table_done, start_ok, mem_we;
  logic            unused_bits;

`ifdef SEQ_PAUSE_EN
  assign hold = pause_i && (state != IDLE);
`else
  assign hold = 1'b0;
`endif

  // Current frame words; the table cannot change while a sequence is running.
  assign w0 = mem[{CUR_FRAME[AW-1:0], 2'd0}];
  assign w1 = mem[{CUR_FRAME[AW-1:0], 2'd1}];
  assign w2 = mem[{CUR_FRAME[AW-1:0], 2'd2}];
  assign w3 = mem[{CUR_FRAME[AW-1:0], 2'd3}];
  assign unused_bits = ^{w0, w1};

  assign en_rise    = enable_i && !en_q;
  assign en_fall    = !enable_i && en_q;
  assign trig_hit   = ((inp_i ^ w0[16 +: NUM_INP]) & w0[24 +: NUM_INP]) == '0;
  assign in_phase   = (state == PHASE1) || (state == PHASE2);
  assign ph_ticks   = (state == PHASE1) ? w2 : w3;
  assign ph_tgt     = (ph_ticks == 32'd0) ? 32'd1 : ph_ticks;
  assign pre_wrap   = pre_cnt == ps_lat - 32'd1;
  assign phase_end  = in_phase && pre_wrap && (tick_cnt == ph_tgt - 32'd1);
  assign rep_more   = (w0[15:0] == 16'd0) || (CUR_FCYCLE < {16'd0, w0[15:0]});
  assign last_frame = CUR_FRAME == ({16'd0, tbl_len} - 32'd1);
  assign cyc_done   = (TABLE_CYCLE != 32'd0) && (CUR_TCYCLE == TABLE_CYCLE);
  assign table_done = !rep_more && last_frame && cyc_done;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (en_rise && tbl_len != 16'd0) state_n = WAIT_TRIG;
      WAIT_TRIG: if (trig_hit) state_n = PHASE1;
      PHASE1:    if (phase_end) state_n = PHASE2;
      PHASE2:    if (phase_end) state_n = table_done ? IDLE : WAIT_TRIG;
      default:   state_n = IDLE;
    endcase
    if (hold)    state_n = state;
    if (en_fall) state_n = IDLE;
  end

  // Sequencer registers: outputs, position counters and phase timing
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_q       <= 1'b0;
      active_o   <= 1'b0;
      out_o      <= '0;
      CUR_FRAME  <= '0;
      CUR_FCYCLE <= '0;
      CUR_TCYCLE <= '0;
      pre_cnt    <= '0;
      tick_cnt   <= '0;
      ps_lat     <= 32'd1;
    end else begin
      en_q     <= enable_i;
      active_o <= state_n != IDLE;
      case (state_n)
        PHASE1:  out_o <= w1[NUM_OUT-1:0];
        PHASE2:  out_o <= w1[8 +: NUM_OUT];
        default: out_o <= '0;
      endcase

      if (state == IDLE && state_n == WAIT_TRIG) begin
        CUR_FRAME  <= '0;
        CUR_FCYCLE <= 32'd1;
        CUR_TCYCLE <= 32'd1;
      end else if (state == PHASE2 && state_n == WAIT_TRIG) begin
        if (rep_more) begin
          CUR_FCYCLE <= CUR_FCYCLE + 32'd1;
        end else begin
          CUR_FCYCLE <= 32'd1;
          if (last_frame) begin
            CUR_FRAME  <= '0;
            CUR_TCYCLE <= CUR_TCYCLE + 32'd1;
          end else begin
            CUR_FRAME <= CUR_FRAME + 32'd1;
          end
        end
      end

      // Prescaler restarts on every phase entry so phase length is exact.
      if (state_n != state && (state_n == PHASE1 || state_n == PHASE2)) begin
        pre_cnt  <= '0;
        tick_cnt <= '0;
        ps_lat   <= (PRESCALE > 32'd1) ? PRESCALE : 32'd1;
      end else if (in_phase && !hold) begin
        if (pre_wrap) begin
          pre_cnt  <= '0;
          tick_cnt <= tick_cnt + 32'd1;
        end else begin
          pre_cnt <= pre_cnt + 32'd1;
        end
      end
    end
  end

  // Table loading and health flags
  assign start_ok = TABLE_START && !active_o;
  assign mem_we   = TABLE_WSTB && !start_ok && !active_o && (wptr < WPW'(WORDS));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr    <= '0;
      tbl_len <= '0;
      HEALTH  <= '0;
    end else begin
      if (start_ok) begin
        wptr   <= '0;
        HEALTH <= '0;
      end else if (TABLE_WSTB) begin
        if (mem_we) wptr <= wptr + WPW'(1);
        else        HEALTH[0] <= 1'b1;
      end
      if (TABLE_LENGTH_WSTB) begin
        if (active_o)
          HEALTH[0] <= 1'b1;
        else if (TABLE_LENGTH == 16'd0 || {16'd0, TABLE_LENGTH} > 32'(DEPTH))
          HEALTH[1] <= 1'b1;
        else
          tbl_len <= TABLE_LENGTH;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wptr[AW+1:0]] <= TABLE_DATA;
  end

endmodule

// File: tb/tb_seq_table_engine.sv
// Directed bench for seq_table_engine (small DEPTH so table overflow is cheap to reach).
module tb_seq_table_engine;

  localparam int NI = 4;
  localparam int NO = 6;
  localparam int DP = 8;

  logic          clk_i = 1'b0;
  logic          reset_i, enable_i;
  logic [NI-1:0] inp_i;
  logic [NO-1:0] out_o;
  logic          active_o;
  logic [31:0]   PRESCALE, TABLE_DATA, TABLE_CYCLE;
  logic          TABLE_START, TABLE_WSTB, TABLE_LENGTH_WSTB;
  logic [15:0]   TABLE_LENGTH;
  logic [31:0]   CUR_FRAME, CUR_FCYCLE, CUR_TCYCLE;
  logic [1:0]    HEALTH;

  int n_chk = 0;
  int n_fail = 0;

  seq_table_engine #(.NUM_INP(NI), .NUM_OUT(NO), .DEPTH(DP)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .inp_i(inp_i),
    .out_o(out_o), .active_o(active_o), .PRESCALE(PRESCALE),
    .TABLE_START(TABLE_START), .TABLE_DATA(TABLE_DATA), .TABLE_WSTB(TABLE_WSTB),
    .TABLE_LENGTH(TABLE_LENGTH), .TABLE_LENGTH_WSTB(TABLE_LENGTH_WSTB),
    .TABLE_CYCLE(TABLE_CYCLE), .CUR_FRAME(CUR_FRAME), .CUR_FCYCLE(CUR_FCYCLE),
    .CUR_TCYCLE(CUR_TCYCLE), .HEALTH(HEALTH)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr_word(input logic [31:0] d);
    TABLE_DATA = d; TABLE_WSTB = 1'b1; step(); TABLE_WSTB = 1'b0;
  endtask

  task automatic wr_frame(input logic [15:0] rep, input logic [7:0] val, input logic [7:0] mask,
                          input logic [7:0] p1, input logic [7:0] p2,
                          input logic [31:0] t1, input logic [31:0] t2);
    wr_word({mask, val, rep});
    wr_word({16'd0, p2, p1});
    wr_word(t1);
    wr_word(t2);
  endtask

  task automatic tbl_start();
    TABLE_START = 1'b1; step(); TABLE_START = 1'b0;
  endtask

  task automatic set_len(input logic [15:0] n);
    TABLE_LENGTH = n; TABLE_LENGTH_WSTB = 1'b1; step(); TABLE_LENGTH_WSTB = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; #1;
    n_chk++; if (out_o !== '0) begin n_fail++; $display("FAIL reset_out: got %0h want 0", out_o); end
    n_chk++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %0b want 0", active_o); end
    n_chk++; if (CUR_FRAME !== 32'd0 || CUR_FCYCLE !== 32'd0 || CUR_TCYCLE !== 32'd0) begin
      n_fail++; $display("FAIL reset_cur: got %0d/%0d/%0d want 0/0/0", CUR_FRAME, CUR_FCYCLE, CUR_TCYCLE); end
    n_chk++; if (HEALTH !== 2'b00) begin n_fail++; $display("FAIL reset_health: got %0b want 00", HEALTH); end
    step(); step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic test_length_err();
    set_len(16'd0);
    n_chk++; if (HEALTH !== 2'b10) begin n_fail++; $display("FAIL len0_health: got %0b want 10", HEALTH); end
    set_len(16'(DP + 1));
    n_chk++; if (HEALTH !== 2'b10) begin n_fail++; $display("FAIL lenbig_health: got %0b want 10", HEALTH); end
    enable_i = 1'b1; step(); step();
    n_chk++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL len0_enable: active got %0b want 0", active_o); end
    enable_i = 1'b0; step();
    tbl_start();
    n_chk++; if (HEALTH !== 2'b00) begin n_fail++; $display("FAIL start_clears: got %0b want 00", HEALTH); end
  endtask

  task automatic test_overflow();
    tbl_start();
    for (int i = 0; i < 4 * DP; i++) wr_word(32'(i));
    n_chk++; if (HEALTH !== 2'b00) begin n_fail++; $display("FAIL fill_health: got %0b want 00", HEALTH); end
    wr_word(32'hFFFF_FFFF);
    n_chk++; if (HEALTH !== 2'b01) begin n_fail++; $display("FAIL overflow_health: got %0b want 01", HEALTH); end
    tbl_start();
  endtask

  task automatic test_basic();
    logic [NO-1:0] exp_out [13] = '{0, 1, 1, 1, 2, 2, 0, 1, 1, 1, 2, 2, 0};
    tbl_start();
    wr_frame(16'd2, 8'h00, 8'h00, 8'h01, 8'h02, 32'd3, 32'd2);
    set_len(16'd1);
    PRESCALE = 32'd1; TABLE_CYCLE = 32'd1;
    enable_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      n_chk++; if (out_o !== exp_out[i] || active_o !== (i < 12)) begin
        n_fail++; $display("FAIL basic_seq[%0d]: out %0h active %0b want out %0h active %0b",
                           i, out_o, active_o, exp_out[i], (i < 12)); end
      if (i == 6) begin
        n_chk++; if (CUR_FCYCLE !== 32'd2) begin n_fail++; $display("FAIL basic_fcycle: got %0d want 2", CUR_FCYCLE); end
      end
    end
    n_chk++; if (CUR_FRAME !== 32'd0 || CUR_FCYCLE !== 32'd2 || CUR_TCYCLE !== 32'd1) begin
      n_fail++; $display("FAIL basic_hold: got %0d/%0d/%0d want 0/2/1", CUR_FRAME, CUR_FCYCLE, CUR_TCYCLE); end
    enable_i = 1'b0; step();
  endtask

  task automatic test_trigger();
    tbl_start();
    wr_frame(16'd1, 8'h01, 8'h31, 8'hC5, 8'h0A, 32'd1, 32'd1);
    set_len(16'd1);
    inp_i = '0;
    enable_i = 1'b1; step();
    for (int i = 0; i < 10; i++) begin
      step();
      n_chk++; if (out_o !== '0 || active_o !== 1'b1) begin
        n_fail++; $display("FAIL trig_wait[%0d]: out %0h active %0b want 0/1", i, out_o, active_o); end
    end
    inp_i = 4'h1; step();
    n_chk++; if (out_o !== 6'h05) begin n_fail++; $display("FAIL trig_phase1: got %0h want 05", out_o); end
    step();
    n_chk++; if (out_o !== 6'h0A) begin n_fail++; $display("FAIL trig_phase2: got %0h want 0a", out_o); end
    step();
    n_chk++; if (active_o !== 1'b0 || out_o !== '0) begin
      n_fail++; $display("FAIL trig_end: active %0b out %0h want 0/0", active_o, out_o); end
    inp_i = '0; enable_i = 1'b0; step();
  endtask

  task automatic test_cycles();
    tbl_start();
    wr_frame(16'd1, 8'h00, 8'h00, 8'h01, 8'h02, 32'd1, 32'd1);
    wr_frame(16'd1, 8'h00, 8'h00, 8'h04, 8'h08, 32'd1, 32'd1);
    set_len(16'd2);
    TABLE_CYCLE = 32'd3;
    enable_i = 1'b1;
    for (int s = 1; s <= 19; s++) begin
      step();
      if ((s - 1) % 3 == 0 && s < 19) begin
        n_chk++; if (CUR_FRAME !== 32'(((s - 1) / 3) % 2) || CUR_TCYCLE !== 32'(1 + (s - 1) / 6)) begin
          n_fail++; $display("FAIL cyc_pos[%0d]: frame %0d tcycle %0d want %0d/%0d", s, CUR_FRAME, CUR_TCYCLE,
                             ((s - 1) / 3) % 2, 1 + (s - 1) / 6); end
      end
      if (s == 5) begin
        n_chk++; if (out_o !== 6'h04) begin n_fail++; $display("FAIL cyc_f1_out: got %0h want 04", out_o); end
      end
    end
    n_chk++; if (active_o !== 1'b0 || CUR_TCYCLE !== 32'd3 || CUR_FRAME !== 32'd1) begin
      n_fail++; $display("FAIL cyc_end: active %0b tcycle %0d frame %0d want 0/3/1", active_o, CUR_TCYCLE, CUR_FRAME); end
    enable_i = 1'b0; TABLE_CYCLE = 32'd1; step();
  endtask

  task automatic test_prescale();
    int c1 = 0;
    int c2 = 0;
    tbl_start();
    wr_frame(16'd1, 8'h00, 8'h00, 8'h11, 8'h22, 32'd2, 32'd1);
    set_len(16'd1);
    PRESCALE = 32'd5;
    enable_i = 1'b1; step(); step();
    for (int i = 0; i < 40; i++) begin
      if (out_o !== 6'h11) break;
      c1++; step();
    end
    for (int i = 0; i < 40; i++) begin
      if (out_o !== 6'h22) break;
      c2++; step();
    end
    n_chk++; if (c1 != 10) begin n_fail++; $display("FAIL pre_phase1_len: got %0d want 10", c1); end
    n_chk++; if (c2 != 5) begin n_fail++; $display("FAIL pre_phase2_len: got %0d want 5", c2); end
    n_chk++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL pre_end: active %0b want 0", active_o); end
    PRESCALE = 32'd1; enable_i = 1'b0; step();
  endtask

  task automatic test_abort();
    tbl_start();
    wr_frame(16'd0, 8'h00, 8'h00, 8'h03, 8'h30, 32'd100, 32'd1);
    set_len(16'd1);
    TABLE_CYCLE = 32'd0;
    enable_i = 1'b1; step(); step(); step();
    n_chk++; if (out_o !== 6'h03 || active_o !== 1'b1) begin
      n_fail++; $display("FAIL abort_run: out %0h active %0b want 03/1", out_o, active_o); end
    TABLE_DATA = 32'hDEAD_BEEF; TABLE_WSTB = 1'b1;
    TABLE_LENGTH = 16'd2; TABLE_LENGTH_WSTB = 1'b1;
    step();
    TABLE_WSTB = 1'b0; TABLE_LENGTH_WSTB = 1'b0;
    n_chk++; if (HEALTH !== 2'b01) begin n_fail++; $display("FAIL active_write: got %0b want 01", HEALTH); end
    enable_i = 1'b0; step();
    n_chk++; if (out_o !== '0 || active_o !== 1'b0) begin
      n_fail++; $display("FAIL abort_stop: out %0h active %0b want 0/0", out_o, active_o); end
    n_chk++; if (CUR_FRAME !== 32'd0 || CUR_FCYCLE !== 32'd1 || CUR_TCYCLE !== 32'd1) begin
      n_fail++; $display("FAIL abort_hold: got %0d/%0d/%0d want 0/1/1", CUR_FRAME, CUR_FCYCLE, CUR_TCYCLE); end
    enable_i = 1'b1; step(); step();
    n_chk++; if (out_o !== 6'h03) begin n_fail++; $display("FAIL table_intact: got %0h want 03", out_o); end
    enable_i = 1'b0; step();
    tbl_start();
    n_chk++; if (HEALTH !== 2'b00) begin n_fail++; $display("FAIL health_clear: got %0b want 00", HEALTH); end
  endtask

  task automatic test_reset_midrun();
    enable_i = 1'b1; step(); step(); step();
    reset_i = 1'b1; #1;
    n_chk++; if (out_o !== '0 || active_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_out: out %0h active %0b want 0/0", out_o, active_o); end
    n_chk++; if (CUR_FCYCLE !== 32'd0 || CUR_TCYCLE !== 32'd0) begin
      n_fail++; $display("FAIL midreset_cur: got %0d/%0d want 0/0", CUR_FCYCLE, CUR_TCYCLE); end
    step();
    reset_i = 1'b0;
    step(); step();
    n_chk++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL midreset_len: active %0b want 0", active_o); end
    enable_i = 1'b0; step();
  endtask

  initial begin
    enable_i = 1'b0; inp_i = '0; PRESCALE = 32'd1; TABLE_CYCLE = 32'd1;
    TABLE_START = 1'b0; TABLE_DATA = '0; TABLE_WSTB = 1'b0;
    TABLE_LENGTH = '0; TABLE_LENGTH_WSTB = 1'b0;
    test_reset();
    test_length_err();
    test_overflow();
    test_basic();
    test_trigger();
    test_cycles();
    test_prescale();
    test_abort();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
